sudoku_wb_arbiter: RTL and testbench

// - 2-master -> 1-slave Wishbone arbiter in front of the sudoku_accelerator slave port.
// - Master 0 is the management SoC bus; master 1 is the UART command bridge.
// - Round-robin arbitration; grant held for a whole cyc_i burst.
// - Sits between the user-project wrapper and the accelerator instance.

---
 rtl/sudoku_wb_pkg.sv | 43 ++++
 rtl/sudoku_wb_timeout_cnt.sv | 45 ++++
 rtl/sudoku_wb_arbiter.sv | 147 ++++++++++++++
 tb/tb_sudoku_wb_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_wb_pkg.sv
// +----------------------------------------------------------------------------+
// | sudoku_wb_pkg                                                              |
// | Shared types and constants for the sudoku accelerator Wishbone arbiter.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package sudoku_wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  localparam logic [WB_DAT_W-1:0] WB_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  typedef struct packed {
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_SEL_W-1:0] sel;
    logic                we;
    logic                cyc;
    logic                stb;
  } wb_req_t;

  // One-hot {m1,m0} grant vector for a given arbiter state.
  function automatic logic [1:0] state_to_grant(input arb_state_e s);
    return {s == ST_GNT1, s == ST_GNT0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sudoku_wb_timeout_cnt.sv
// +----------------------------------------------------------------------------+
// | sudoku_wb_timeout_cnt                                                      |
// | Stall counter; expire_o is high while the count sits at TIMEOUT_CYCLES.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module sudoku_wb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Saturates at the limit so the counter can never wrap past expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/sudoku_wb_arbiter.sv
// +----------------------------------------------------------------------------+
// | sudoku_wb_arbiter                                                          |
// | 2-master round-robin Wishbone arbiter; optional stall timeout via the     |
// | WB_TIMEOUT_EN macro.                                                       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module sudoku_wb_arbiter
  import sudoku_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic [WB_ADR_W-1:0] m0_adr_i,
  input  logic [WB_DAT_W-1:0] m0_dat_i,
  input  logic [WB_SEL_W-1:0] m0_sel_i,
  input  logic                m0_we_i,
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  output logic                m0_ack_o,
  output logic [WB_DAT_W-1:0] m0_dat_o,
  input  logic [WB_ADR_W-1:0] m1_adr_i,
  input  logic [WB_DAT_W-1:0] m1_dat_i,
  input  logic [WB_SEL_W-1:0] m1_sel_i,
  input  logic                m1_we_i,
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  output logic                m1_ack_o,
  output logic [WB_DAT_W-1:0] m1_dat_o,
  output logic [WB_ADR_W-1:0] s_adr_o,
  output logic [WB_DAT_W-1:0] s_dat_o,
  output logic [WB_SEL_W-1:0] s_sel_o,
  output logic                s_we_o,
  output logic                s_cyc_o,
  output logic                s_stb_o,
  input  logic                s_ack_i,
  input  logic [WB_DAT_W-1:0] s_dat_i,
  output logic [1:0]          grant_o,
  output logic                timeout_o
);

  arb_state_e state_q, state_d;
  master_e    last_q, last_d;
  logic [1:0] grant_q;
  logic       timeout_q;

  wb_req_t req_m0, req_m1, req_gnt;
  logic    sel_m0, sel_m1;
  logic    stb_raw, expire, ack_any;
  logic [WB_DAT_W-1:0] rsp_dat;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_GNT0: if (!m0_cyc_i) state_d = m1_cyc_i ? ST_GNT1 : ST_IDLE;
      ST_GNT1: if (!m1_cyc_i) state_d = m0_cyc_i ? ST_GNT0 : ST_IDLE;
      default: begin
        // On a tie the master that was not granted most recently wins.
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = (last_q == M1) ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc_i) begin
          state_d = ST_GNT0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
        end
      end
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_d == ST_GNT0) last_d = M0;
    else if (state_d == ST_GNT1) last_d = M1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      last_q    <= M1;
      grant_q   <= 2'b00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= state_to_grant(state_d);
      timeout_q <= timeout_q | expire;
    end
  end

  assign sel_m0 = (state_q == ST_GNT0);
  assign sel_m1 = (state_q == ST_GNT1);
  assign req_m0 = {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i, m0_cyc_i, m0_stb_i};
  assign req_m1 = {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i, m1_cyc_i, m1_stb_i};

  always_comb begin
    req_gnt = '0;
    if (sel_m0) req_gnt = req_m0;
    else if (sel_m1) req_gnt = req_m1;
  end

  assign stb_raw = req_gnt.stb;

`ifdef WB_TIMEOUT_EN
  logic cnt_hit;

  sudoku_wb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W     (TIMEOUT_W)
  ) u_timeout_cnt (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .inc_i   (stb_raw & ~s_ack_i),
    .clr_i   (s_ack_i | expire | (state_d != state_q)),
    .expire_o(cnt_hit)
  );

  // A real ack in the expiry cycle wins over the forced termination.
  assign expire = cnt_hit & stb_raw & ~s_ack_i;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES < (1 << TIMEOUT_W));
  assign expire     = 1'b0;
`endif

  assign s_adr_o = req_gnt.adr;
  assign s_dat_o = req_gnt.dat;
  assign s_sel_o = req_gnt.sel;
  assign s_we_o  = req_gnt.we;
  assign s_cyc_o = req_gnt.cyc;
  assign s_stb_o = stb_raw & ~expire;

  assign ack_any  = s_ack_i | expire;
  assign rsp_dat  = expire ? WB_TIMEOUT_DATA : s_dat_i;
  assign m0_ack_o = sel_m0 & ack_any;
  assign m1_ack_o = sel_m1 & ack_any;
  assign m0_dat_o = sel_m0 ? rsp_dat : '0;
  assign m1_dat_o = sel_m1 ? rsp_dat : '0;

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_sudoku_wb_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_sudoku_wb_arbiter                                                       |
// | Directed + randomized bench for sudoku_wb_arbiter (honours WB_TIMEOUT_EN).|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sudoku_wb_arbiter;

  localparam int TCYC = 8;
`ifdef WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, s_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i, s_ack_i;
  logic        m0_ack_o, m1_ack_o, s_we_o, s_cyc_o, s_stb_o, timeout_o;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: owner is -1 when nobody holds the bus.
  int own   = -1;
  int last  = 1;
  int stall = 0;
  bit tout  = 1'b0;

  sudoku_wb_arbiter #(.TIMEOUT_CYCLES(TCYC), .TIMEOUT_W(8)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_cyc(input int m);
    return (m == 0) ? m0_cyc_i : (m == 1) ? m1_cyc_i : 1'b0;
  endfunction

  function automatic bit own_stb();
    return (own == 0) ? m0_stb_i : (own == 1) ? m1_stb_i : 1'b0;
  endfunction

  function automatic bit model_expire();
    return TO_EN && own_stb() && !s_ack_i && (stall == TCYC);
  endfunction

  task automatic model_update();
    int nown;
    bit ex;
    if (!wb_rst_ni) begin
      own = -1; last = 1; stall = 0; tout = 1'b0;
      return;
    end
    ex = model_expire();
    if (own >= 0 && m_cyc(own))   nown = own;
    else if (m0_cyc_i && m1_cyc_i) nown = 1 - last;
    else if (m0_cyc_i)             nown = 0;
    else if (m1_cyc_i)             nown = 1;
    else                           nown = -1;
    if (nown != own || s_ack_i || ex) stall = 0;
    else if (own_stb())               stall = stall + 1;
    if (nown >= 0) last = nown;
    own  = nown;
    tout = tout | ex;
  endtask

  task automatic chk_all();
    bit ex;
    logic [31:0] rsp;
    ex  = model_expire();
    rsp = ex ? 32'hDEAD_BEEF : s_dat_i;
    check("grant", {30'd0, grant_o}, (own == 0) ? 32'd1 : (own == 1) ? 32'd2 : 32'd0);
    check("s_cyc", {31'd0, s_cyc_o}, {31'd0, m_cyc(own)});
    check("s_stb", {31'd0, s_stb_o}, {31'd0, own_stb() && !ex});
    check("s_adr", s_adr_o, (own == 0) ? m0_adr_i : (own == 1) ? m1_adr_i : 32'd0);
    check("s_dat", s_dat_o, (own == 0) ? m0_dat_i : (own == 1) ? m1_dat_i : 32'd0);
    check("s_sel", {28'd0, s_sel_o}, {28'd0, (own == 0) ? m0_sel_i : (own == 1) ? m1_sel_i : 4'd0});
    check("s_we", {31'd0, s_we_o}, {31'd0, (own == 0) ? m0_we_i : (own == 1) ? m1_we_i : 1'b0});
    check("m0_ack", {31'd0, m0_ack_o}, {31'd0, own == 0 && (s_ack_i || ex)});
    check("m1_ack", {31'd0, m1_ack_o}, {31'd0, own == 1 && (s_ack_i || ex)});
    check("m0_dat", m0_dat_o, (own == 0) ? rsp : 32'd0);
    check("m1_dat", m1_dat_o, (own == 1) ? rsp : 32'd0);
    check("timeout", {31'd0, timeout_o}, {31'd0, tout});
  endtask

  task automatic step();
    @(posedge wb_clk_i);
    model_update();
    #1;
    chk_all();
  endtask

  task automatic idle_masters();
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
  endtask

  task automatic do_reset();
    wb_rst_ni = 0; idle_masters();
    step();
    wb_rst_ni = 1;
  endtask

  initial begin
    wb_rst_ni = 0;
    m0_adr_i = 32'h3000_0000; m0_dat_i = 32'hA5A5_0000; m0_sel_i = 4'hF; m0_we_i = 1;
    m1_adr_i = 32'h3000_0004; m1_dat_i = 32'h0000_5A5A; m1_sel_i = 4'h3; m1_we_i = 0;
    s_dat_i = 32'h0;
    // Reset held with both masters requesting and a spurious slave ack.
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_grant", {30'd0, grant_o}, 32'd0);
      check("rst_scyc", {31'd0, s_cyc_o}, 32'd0);
      check("rst_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
    end
    idle_masters(); wb_rst_ni = 1;
    step();

    // Single master read by m1.
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; m1_adr_i = 32'h3000_0004;
    #1 check("m1_lat", {31'd0, s_cyc_o}, 32'd0);
    step();
    check("m1_grant", {30'd0, grant_o}, 32'd2);
    check("m1_adr", s_adr_o, 32'h3000_0004);
    step();
    s_ack_i = 1; s_dat_i = 32'h1234_5678;
    #1 check("m1_ack", {31'd0, m1_ack_o}, 32'd1);
    check("m1_rdat", m1_dat_o, 32'h1234_5678);
    check("m1_m0ack", {31'd0, m0_ack_o}, 32'd0);
    step();
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    step();
    check("m1_done", {30'd0, grant_o}, 32'd0);

    // Ties after reset: m0 first, then direct hand-over, then alternation.
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    step();
    check("tie_first", {30'd0, grant_o}, 32'd1);
    m0_cyc_i = 0; m0_stb_i = 0;
    step();
    check("tie_handover", {30'd0, grant_o}, 32'd2);
    for (int t = 0; t < 3; t++) begin
      idle_masters();
      step();
      m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
      step();
      check("tie_alt", {30'd0, grant_o}, (t == 1) ? 32'd2 : 32'd1);
    end
    idle_masters();
    step();

    // m0 holds grant through a 4-beat burst while m1 waits.
    m0_cyc_i = 1; m0_stb_i = 1;
    step();
    m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1;
    for (int b = 0; b < 4; b++) begin
      s_dat_i = 32'hB000_0000 + b;
      #1 check("burst_m0ack", {31'd0, m0_ack_o}, 32'd1);
      check("burst_m1ack", {31'd0, m1_ack_o}, 32'd0);
      step();
      check("burst_hold", {30'd0, grant_o}, 32'd1);
    end
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
    step();
    check("burst_next", {30'd0, grant_o}, 32'd2);
    idle_masters();
    step();

    // Reset while m1 has a pending strobe.
    m1_cyc_i = 1; m1_stb_i = 1;
    step();
    check("rmid_gnt", {30'd0, grant_o}, 32'd2);
    wb_rst_ni = 0;
    step();
    check("rmid_scyc", {31'd0, s_cyc_o}, 32'd0);
    check("rmid_grant", {30'd0, grant_o}, 32'd0);
    s_ack_i = 1;
    #1 check("rmid_late_ack", {31'd0, m1_ack_o}, 32'd0);
    idle_masters(); wb_rst_ni = 1;
    step();

    // Stalled write by m0: forced termination only when timeout is built in.
    m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; s_dat_i = 32'h0BAD_F00D;
    step();
    for (int k = 1; k <= TCYC + 1; k++) begin
      step();
      check("to_ack", {31'd0, m0_ack_o}, {31'd0, TO_EN && k == TCYC});
      if (k == TCYC) begin
        check("to_dat", m0_dat_o, TO_EN ? 32'hDEAD_BEEF : 32'h0BAD_F00D);
        check("to_stb", {31'd0, s_stb_o}, {31'd0, !TO_EN});
      end
    end
    check("to_flag", {31'd0, timeout_o}, {31'd0, TO_EN});
    idle_masters();
    repeat (3) step();
    check("to_sticky", {31'd0, timeout_o}, {31'd0, TO_EN});

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bit heavy_stall;
      heavy_stall = ((c / 60) % 2) == 1;
      wb_rst_ni = ($urandom_range(0, 149) != 0);
      if (m0_cyc_i) m0_cyc_i = ($urandom_range(0, 5) != 0); else m0_cyc_i = ($urandom_range(0, 2) == 0);
      if (m1_cyc_i) m1_cyc_i = ($urandom_range(0, 5) != 0); else m1_cyc_i = ($urandom_range(0, 2) == 0);
      m0_stb_i = m0_cyc_i && ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i && ($urandom_range(0, 3) != 0);
      m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom); m0_we_i = 1'($urandom);
      m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom); m1_we_i = 1'($urandom);
      s_dat_i  = $urandom;
      s_ack_i  = heavy_stall ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 0);
      #1 chk_all();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
